// File: rtl/vend_credit_fsm_if.sv
// Bus bundle between the vending front panel and the credit controller.
// The master side drives coin sensors and purchase/refund requests; the
// slave side (the controller) returns credit, status and coin-return pulses.
interface vend_credit_fsm_if #(
    parameter int CREDIT_W = 8
) ();
    logic                quarters;
    logic                dimes;
    logic                nickles;
    logic                buy;
    logic                refund;
    logic [CREDIT_W-1:0] credit;
    logic                can_buy;
    logic                vending;
    logic                quarter_out;
    logic                dime_out;
    logic                nickel_out;
    logic                coin_reject;
    logic                busy;

    modport master (
        output quarters, dimes, nickles, buy, refund,
        input  credit, can_buy, vending, quarter_out, dime_out,
               nickel_out, coin_reject, busy
    );

    modport slave (
        input  quarters, dimes, nickles, buy, refund,
        output credit, can_buy, vending, quarter_out, dime_out,
               nickel_out, coin_reject, busy
    );
endinterface

// File: rtl/vend_credit_fsm.sv
// Credit / vend / change controller.
// Coins are edge-detected and summed into a credit register capped at
// MAX_CREDIT. In IDLE a Buy consumes PRICE (repeating while held), and a
// Refund moves to DISPENSE, which pays the balance back one coin per cycle,
// largest coin first, returning to IDLE exactly when credit reaches zero.
module vend_credit_fsm #(
    parameter int PRICE      = 25,
    parameter int MAX_CREDIT = 200,
    parameter int CREDIT_W   = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    vend_credit_fsm_if.slave   bus
);

    // One extra bit so credit + incoming coins can exceed the ceiling
    // without wrapping before the overflow test.
    localparam int SUM_W = CREDIT_W + 1;

    localparam logic [SUM_W-1:0] C_PRICE = SUM_W'(PRICE);
    localparam logic [SUM_W-1:0] C_MAX   = SUM_W'(MAX_CREDIT);
    localparam logic [SUM_W-1:0] C_25    = SUM_W'(25);
    localparam logic [SUM_W-1:0] C_10    = SUM_W'(10);
    localparam logic [SUM_W-1:0] C_5     = SUM_W'(5);

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_DISPENSE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_prev_q;
    logic                r_prev_d;
    logic                r_prev_n;

    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] w_credit_nxt;
    logic                r_vending;
    logic                w_vending_nxt;
    logic                r_quarter_out;
    logic                w_quarter_nxt;
    logic                r_dime_out;
    logic                w_dime_nxt;
    logic                r_nickel_out;
    logic                w_nickel_nxt;
    logic                r_coin_reject;
    logic                w_reject_nxt;

    logic                w_edge_q;
    logic                w_edge_d;
    logic                w_edge_n;
    logic [SUM_W-1:0]    w_coin_in;
    logic [SUM_W-1:0]    w_credit_ext;
    logic [SUM_W-1:0]    w_vend_amt;
    logic [SUM_W-1:0]    w_sum;

    // Total value of the coin edges seen this cycle (0..40 cents).
    function automatic logic [SUM_W-1:0] coin_value(input logic q, input logic d,
                                                    input logic n);
        logic [SUM_W-1:0] acc;
        acc = '0;
        if (q) acc = acc + C_25;
        if (d) acc = acc + C_10;
        if (n) acc = acc + C_5;
        return acc;
    endfunction

    assign w_edge_q     = bus.quarters & ~r_prev_q;
    assign w_edge_d     = bus.dimes    & ~r_prev_d;
    assign w_edge_n     = bus.nickles  & ~r_prev_n;
    assign w_coin_in    = coin_value(w_edge_q, w_edge_d, w_edge_n);
    assign w_credit_ext = {1'b0, r_credit};

    // Coin sensor history for rising-edge detection; tracks in every state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev_q <= 1'b0;
            r_prev_d <= 1'b0;
            r_prev_n <= 1'b0;
        end else begin
            r_prev_q <= bus.quarters;
            r_prev_d <= bus.dimes;
            r_prev_n <= bus.nickles;
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, next credit and next pulse outputs.
    always_comb begin
        w_state_nxt   = r_state;
        w_credit_nxt  = r_credit;
        w_vending_nxt = 1'b0;
        w_quarter_nxt = 1'b0;
        w_dime_nxt    = 1'b0;
        w_nickel_nxt  = 1'b0;
        w_reject_nxt  = 1'b0;
        w_vend_amt    = '0;
        w_sum         = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.buy && (w_credit_ext >= C_PRICE)) begin
                    w_vend_amt = C_PRICE;
                end
                w_sum = w_credit_ext - w_vend_amt + w_coin_in;
                // Overflow refuses every coin of this cycle but keeps the sale.
                if (w_sum > C_MAX) begin
                    w_reject_nxt = 1'b1;
                    w_credit_nxt = CREDIT_W'(w_credit_ext - w_vend_amt);
                end else begin
                    w_credit_nxt = CREDIT_W'(w_sum);
                end
                // A sale outranks a refund requested in the same cycle.
                if (w_vend_amt != '0) begin
                    w_vending_nxt = 1'b1;
                end else if (bus.refund && (r_credit != '0)) begin
                    w_state_nxt = S_DISPENSE;
                end
            end
            S_DISPENSE: begin
                w_reject_nxt = (w_coin_in != '0);
                // Credit is always a multiple of 5, so the nickel branch
                // never underflows and the loop ends exactly at zero.
                if (w_credit_ext >= C_25) begin
                    w_quarter_nxt = 1'b1;
                    w_credit_nxt  = CREDIT_W'(w_credit_ext - C_25);
                end else if (w_credit_ext >= C_10) begin
                    w_dime_nxt    = 1'b1;
                    w_credit_nxt  = CREDIT_W'(w_credit_ext - C_10);
                end else begin
                    w_nickel_nxt  = 1'b1;
                    w_credit_nxt  = CREDIT_W'(w_credit_ext - C_5);
                end
                if (w_credit_nxt == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Credit register and registered pulse outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_credit      <= '0;
            r_vending     <= 1'b0;
            r_quarter_out <= 1'b0;
            r_dime_out    <= 1'b0;
            r_nickel_out  <= 1'b0;
            r_coin_reject <= 1'b0;
        end else begin
            r_credit      <= w_credit_nxt;
            r_vending     <= w_vending_nxt;
            r_quarter_out <= w_quarter_nxt;
            r_dime_out    <= w_dime_nxt;
            r_nickel_out  <= w_nickel_nxt;
            r_coin_reject <= w_reject_nxt;
        end
    end

    assign bus.credit      = r_credit;
    assign bus.can_buy     = (r_state == S_IDLE) && (r_credit >= CREDIT_W'(PRICE));
    assign bus.vending     = r_vending;
    assign bus.quarter_out = r_quarter_out;
    assign bus.dime_out    = r_dime_out;
    assign bus.nickel_out  = r_nickel_out;
    assign bus.coin_reject = r_coin_reject;
    assign bus.busy        = (r_state == S_DISPENSE);

endmodule

// File: tb/tb_vend_credit_fsm.sv
// Bench for vend_credit_fsm: directed scenarios followed by random traffic,
// all predicted by a cents-level reference model and checked by a monitor
// that pops one expected snapshot per clock.
module tb_vend_credit_fsm;

    localparam int PRICE      = 25;
    localparam int MAX_CREDIT = 200;
    localparam int CREDIT_W   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    vend_credit_fsm_if #(.CREDIT_W(CREDIT_W)) bus ();

    vend_credit_fsm #(
        .PRICE      (PRICE),
        .MAX_CREDIT (MAX_CREDIT),
        .CREDIT_W   (CREDIT_W)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        int credit;
        bit can_buy;
        bit vending;
        bit qo;
        bit dout;
        bit no;
        bit rej;
        bit busy;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: balance in cents, whether change is being paid,
    // and last seen coin sensor levels.
    int m_credit = 0;
    bit m_disp   = 1'b0;
    bit m_pq     = 1'b0;
    bit m_pd     = 1'b0;
    bit m_pn     = 1'b0;

    task automatic model_step(input bit q, input bit d, input bit n,
                              input bit b, input bit r, output exp_t e);
        int coin;
        int v;
        int nn;
        int old;
        int denom[3];
        denom[0] = 25; denom[1] = 10; denom[2] = 5;
        e.credit = 0; e.can_buy = 0; e.vending = 0; e.qo = 0;
        e.dout = 0; e.no = 0; e.rej = 0; e.busy = 0;
        coin = ((q && !m_pq) ? 25 : 0) + ((d && !m_pd) ? 10 : 0) + ((n && !m_pn) ? 5 : 0);
        m_pq = q; m_pd = d; m_pn = n;
        old = m_credit;
        if (!m_disp) begin
            v  = (b && old >= PRICE) ? PRICE : 0;
            nn = old - v + coin;
            if (nn > MAX_CREDIT) begin
                e.rej    = 1'b1;
                m_credit = old - v;
            end else begin
                m_credit = nn;
            end
            if (v > 0) e.vending = 1'b1;
            else if (r && old > 0) m_disp = 1'b1;
        end else begin
            e.rej = (coin > 0);
            for (int k = 0; k < 3; k++) begin
                if (denom[k] <= m_credit) begin
                    m_credit = m_credit - denom[k];
                    if (k == 0) e.qo = 1'b1;
                    else if (k == 1) e.dout = 1'b1;
                    else e.no = 1'b1;
                    break;
                end
            end
            if (m_credit == 0) m_disp = 1'b0;
        end
        e.credit  = m_credit;
        e.busy    = m_disp;
        e.can_buy = !m_disp && (m_credit >= PRICE);
    endtask

    task automatic cyc(input bit q, input bit d, input bit n, input bit b, input bit r);
        exp_t e;
        @(negedge clk);
        bus.quarters = q;
        bus.dimes    = d;
        bus.nickles  = n;
        bus.buy      = b;
        bus.refund   = r;
        model_step(q, d, n, b, r, e);
        sb.push_back(e);
    endtask

    task automatic insert(input int kind);
        cyc(kind == 0, kind == 1, kind == 2, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic refund_drain();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20 && m_disp; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.quarters = 1'b0;
        bus.dimes    = 1'b0;
        bus.nickles  = 1'b0;
        bus.buy      = 1'b0;
        bus.refund   = 1'b0;
        #1;
        n_cmp++;
        if (bus.credit !== '0 || bus.vending !== 1'b0 || bus.quarter_out !== 1'b0 ||
            bus.dime_out !== 1'b0 || bus.nickel_out !== 1'b0 || bus.coin_reject !== 1'b0 ||
            bus.busy !== 1'b0 || bus.can_buy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state t=%0t got credit=%0d vend=%b q/d/n=%b%b%b rej=%b busy=%b canbuy=%b expected all zero",
                     $time, bus.credit, bus.vending, bus.quarter_out, bus.dime_out,
                     bus.nickel_out, bus.coin_reject, bus.busy, bus.can_buy);
        end
        m_credit = 0; m_disp = 1'b0; m_pq = 1'b0; m_pd = 1'b0; m_pn = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: one snapshot per clock, compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (bus.credit !== CREDIT_W'(e.credit) || bus.can_buy !== e.can_buy ||
                    bus.vending !== e.vending || bus.quarter_out !== e.qo ||
                    bus.dime_out !== e.dout || bus.nickel_out !== e.no ||
                    bus.coin_reject !== e.rej || bus.busy !== e.busy) begin
                    n_bad++;
                    $display("FAIL cycle_check t=%0t got credit=%0d canbuy=%b vend=%b qdn=%b%b%b rej=%b busy=%b expected credit=%0d canbuy=%b vend=%b qdn=%b%b%b rej=%b busy=%b",
                             $time, bus.credit, bus.can_buy, bus.vending, bus.quarter_out,
                             bus.dime_out, bus.nickel_out, bus.coin_reject, bus.busy,
                             e.credit, e.can_buy, e.vending, e.qo, e.dout, e.no, e.rej, e.busy);
                end
            end
        end
    end

    initial begin
        bus.quarters = 1'b0;
        bus.dimes    = 1'b0;
        bus.nickles  = 1'b0;
        bus.buy      = 1'b0;
        bus.refund   = 1'b0;

        do_reset();

        // Single quarter then one buy.
        insert(0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);

        // 65 cents refunded as Q, Q, D, N.
        insert(0); insert(0); insert(1); insert(2);
        refund_drain();

        // Ceiling: 190, refused quarter, accepted nickel.
        for (int i = 0; i < 7; i++) insert(0);
        insert(1); insert(2);
        insert(0);
        insert(2);
        refund_drain();

        // Buy beats Refund in the same cycle.
        insert(0); insert(0);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0);
        refund_drain();

        // Dime inserted while change is being paid.
        insert(0); insert(0); insert(1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 20 && m_disp; i++) cyc(0, 0, 0, 0, 0);

        // Repeated sales while Buy stays high.
        insert(0); insert(0); insert(0); insert(1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);
        refund_drain();

        // Reset while paying change with 40 cents still owed.
        insert(0); insert(0); insert(1); insert(2);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);

        // Quarter sensor held high for ten cycles.
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        refund_drain();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 19) == 0);
            if (i == 1500) do_reset();
        end

        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain_check got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
